// File: rtl/dc_tag_pkg.sv
// Shared types and constants for the dcache tag-bank write dispatch block.
// Holds default widths, bank count, the request record and the dispatch state enum.
package dc_tag_pkg;

  localparam int IDX_W_DEF = 6;
  localparam int TAG_W_DEF = 20;
  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [BANK_W-1:0]    bank;
    logic [IDX_W_DEF-1:0] index;
    logic [TAG_W_DEF-1:0] tag;
  } req_t;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
    logic [NUM_BANKS-1:0] oh;
    oh       = '0;
    oh[bank] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dc_tag_bank_write_dispatch_if.sv
// Controller-side request port and shared bank-side write port of the tag dispatch.
// With DC_TAG_WR_PARITY_EN defined, bank_tag carries an extra even-parity bit at TAG_W.
interface dc_tag_bank_write_dispatch_if #(
  parameter int IDX_W = dc_tag_pkg::IDX_W_DEF,
  parameter int TAG_W = dc_tag_pkg::TAG_W_DEF
);

`ifdef DC_TAG_WR_PARITY_EN
  localparam int BANK_TAG_W = TAG_W + 1;
`else
  localparam int BANK_TAG_W = TAG_W;
`endif

  logic                                 req_valid;
  logic                                 req_ready;
  logic [dc_tag_pkg::BANK_W-1:0]        req_bank;
  logic [IDX_W-1:0]                     req_index;
  logic [TAG_W-1:0]                     req_tag;

  logic [dc_tag_pkg::NUM_BANKS-1:0]     bank_valid;
  logic [dc_tag_pkg::NUM_BANKS-1:0]     bank_ready;
  logic [IDX_W-1:0]                     bank_index;
  logic [BANK_TAG_W-1:0]                bank_tag;

  logic                                 busy;

  // master = surrounding environment (controller + banks), slave = dispatch block
  modport master (
    output req_valid, req_bank, req_index, req_tag, bank_ready,
    input  req_ready, bank_valid, bank_index, bank_tag, busy
  );

  modport slave (
    input  req_valid, req_bank, req_index, req_tag, bank_ready,
    output req_ready, bank_valid, bank_index, bank_tag, busy
  );

endinterface

// File: rtl/dc_tag_wr_fifo.sv
// Generic synchronous FIFO with full/empty flags; DEPTH must be a power of 2, >= 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dc_tag_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it was written, and skipping
  // reset lets the array map onto plain flops or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dc_tag_bank_write_dispatch.sv
// Routes tag-write requests in order through a small FIFO to one of four tag banks.
// Define DC_TAG_WR_PARITY_EN to append an even-parity bit to the tag at push time.
module dc_tag_bank_write_dispatch
  import dc_tag_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  dc_tag_bank_write_dispatch_if.slave    bus
);

`ifdef DC_TAG_WR_PARITY_EN
  localparam int TW = TAG_W + 1;
`else
  localparam int TW = TAG_W;
`endif

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [IDX_W-1:0]  index;
    logic [TW-1:0]     tag;
  } entry_t;

  entry_t               wr_entry;
  entry_t               head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 handshake;

  state_t               state;
  logic [BANK_W-1:0]    sel;
  logic [NUM_BANKS-1:0] bank_valid_q;
  logic [IDX_W-1:0]     bank_index_q;
  logic [TW-1:0]        bank_tag_q;

  assign push          = bus.req_valid && !full;
  assign bus.req_ready = !full;

  // NOTE: default every always_comb output first so no path can infer a latch.
  always_comb begin
    wr_entry       = '0;
    wr_entry.bank  = bus.req_bank;
    wr_entry.index = bus.req_index;
`ifdef DC_TAG_WR_PARITY_EN
    wr_entry.tag   = {^bus.req_tag, bus.req_tag};
`else
    wr_entry.tag   = bus.req_tag;
`endif
  end

  dc_tag_wr_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Only the selected bank's ready completes a write; the others are don't-care.
  assign handshake = (state == SEND) && bus.bank_ready[sel];
  assign pop       = !empty && ((state == IDLE) || handshake);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sel          <= '0;
      bank_valid_q <= '0;
      bank_index_q <= '0;
      bank_tag_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state        <= SEND;
            sel          <= head.bank;
            bank_valid_q <= bank_onehot(head.bank);
            bank_index_q <= head.index;
            bank_tag_q   <= head.tag;
          end
        end
        SEND: begin
          if (handshake) begin
            if (pop) begin
              sel          <= head.bank;
              bank_valid_q <= bank_onehot(head.bank);
              bank_index_q <= head.index;
              bank_tag_q   <= head.tag;
            end else begin
              state        <= IDLE;
              bank_valid_q <= '0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          bank_valid_q <= '0;
        end
      endcase
    end
  end

  assign bus.bank_valid = bank_valid_q;
  assign bus.bank_index = bank_index_q;
  assign bus.bank_tag   = bank_tag_q;
  assign bus.busy       = (state == SEND) || !empty;

endmodule

// File: tb/tb_dc_tag_bank_write_dispatch.sv
// Bench for dc_tag_bank_write_dispatch: directed vector table, async-reset sequence,
// then random traffic checked against a queue-based reference model.
module tb_dc_tag_bank_write_dispatch;
  import dc_tag_pkg::*;

  localparam int IDX_W = 6;
  localparam int TAG_W = 20;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dc_tag_bank_write_dispatch_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  dc_tag_bank_write_dispatch #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every accepted, not yet completed write in order; the head is
  // on the bank port once it has been shown, everything else waits in the FIFO.
  req_t mq[$];
  bit   showing  = 1'b0;
  bit   last_acc = 1'b1;

  task automatic model_edge();
    int fifo_cnt;
    bit acc;
    req_t r;
    fifo_cnt = mq.size() - (showing ? 1 : 0);
    acc      = bus.req_valid && (fifo_cnt < DEPTH);
    if (showing) begin
      if (bus.bank_ready[mq[0].bank]) begin
        void'(mq.pop_front());
        showing = (mq.size() > 0);
      end
    end else if (mq.size() > 0) begin
      showing = 1'b1;
    end
    if (acc) begin
      r.bank  = bus.req_bank;
      r.index = bus.req_index;
      r.tag   = bus.req_tag;
      mq.push_back(r);
    end
    last_acc = acc;
  endtask

  task automatic model_check(input string tag);
    logic [3:0] exp_bv;
    int         waiting;
    exp_bv  = showing ? (4'b0001 << mq[0].bank) : 4'b0000;
    waiting = mq.size() - (showing ? 1 : 0);
    check({tag, " bank_valid"}, bus.bank_valid, exp_bv);
    check({tag, " req_ready"}, bus.req_ready, waiting < DEPTH);
    check({tag, " busy"}, bus.busy, mq.size() > 0);
    if (showing) begin
      check({tag, " bank_index"}, bus.bank_index, mq[0].index);
      check({tag, " bank_tag"}, bus.bank_tag[TAG_W-1:0], mq[0].tag);
`ifdef DC_TAG_WR_PARITY_EN
      check({tag, " parity"}, bus.bank_tag[TAG_W], ^mq[0].tag);
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    bit          v;
    logic [1:0]  bank;
    logic [5:0]  idx;
    logic [19:0] tag;
    logic [3:0]  rdy;
    logic [3:0]  exp_bv;
    logic [5:0]  exp_idx;
    logic [19:0] exp_tag;
    bit          exp_rr;
    bit          exp_busy;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // single write
    tbl[0]  = '{1, 1,  5, 'hABCDE, 'hF, 'b0000,  0, 'h00000, 1, 1};
    tbl[1]  = '{0, 0,  0, 'h00000, 'hF, 'b0010,  5, 'hABCDE, 1, 1};
    tbl[2]  = '{0, 0,  0, 'h00000, 'hF, 'b0000,  0, 'h00000, 1, 0};
    // back-to-back to banks 0..3
    tbl[3]  = '{1, 0, 10, 'h00001, 'hF, 'b0000,  0, 'h00000, 1, 1};
    tbl[4]  = '{1, 1, 11, 'h00003, 'hF, 'b0001, 10, 'h00001, 1, 1};
    tbl[5]  = '{1, 2, 12, 'h12345, 'hF, 'b0010, 11, 'h00003, 1, 1};
    tbl[6]  = '{1, 3, 13, 'hFFFFF, 'hF, 'b0100, 12, 'h12345, 1, 1};
    tbl[7]  = '{0, 0,  0, 'h00000, 'hF, 'b1000, 13, 'hFFFFF, 1, 1};
    tbl[8]  = '{0, 0,  0, 'h00000, 'hF, 'b0000,  0, 'h00000, 1, 0};
    // bank 3 stalled until FIFO full, 4th request held, then drain in order
    tbl[9]  = '{1, 3, 20, 'h0AAAA, 'h7, 'b0000,  0, 'h00000, 1, 1};
    tbl[10] = '{1, 3, 21, 'h0BBBB, 'h7, 'b1000, 20, 'h0AAAA, 1, 1};
    tbl[11] = '{1, 3, 22, 'h0CCCC, 'h7, 'b1000, 20, 'h0AAAA, 0, 1};
    tbl[12] = '{1, 3, 23, 'h0DDDD, 'h7, 'b1000, 20, 'h0AAAA, 0, 1};
    tbl[13] = '{1, 3, 23, 'h0DDDD, 'hF, 'b1000, 21, 'h0BBBB, 1, 1};
    tbl[14] = '{1, 3, 23, 'h0DDDD, 'hF, 'b1000, 22, 'h0CCCC, 1, 1};
    tbl[15] = '{0, 0,  0, 'h00000, 'hF, 'b1000, 23, 'h0DDDD, 1, 1};
    tbl[16] = '{0, 0,  0, 'h00000, 'hF, 'b0000,  0, 'h00000, 1, 0};
    // head-of-line blocking: bank 0 stalled, bank 1 waits behind it
    tbl[17] = '{1, 0, 30, 'h11111, 'hE, 'b0000,  0, 'h00000, 1, 1};
    tbl[18] = '{1, 1, 31, 'h22222, 'hE, 'b0001, 30, 'h11111, 1, 1};
    tbl[19] = '{0, 0,  0, 'h00000, 'hE, 'b0001, 30, 'h11111, 1, 1};
    tbl[20] = '{0, 0,  0, 'h00000, 'hE, 'b0001, 30, 'h11111, 1, 1};
    tbl[21] = '{0, 0,  0, 'h00000, 'hF, 'b0010, 31, 'h22222, 1, 1};
    tbl[22] = '{0, 0,  0, 'h00000, 'hF, 'b0000,  0, 'h00000, 1, 0};

    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_bank   = '0;
    bus.req_index  = '0;
    bus.req_tag    = '0;
    bus.bank_ready = '0;

    @(negedge clk);
    @(negedge clk);
    check("reset bank_valid", bus.bank_valid, 4'b0000);
    check("reset bank_index", bus.bank_index, 0);
    check("reset bank_tag", bus.bank_tag, 0);
    check("reset busy", bus.busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", bus.req_ready, 1'b1);

    for (int i = 0; i < 23; i++) begin
      bus.req_valid  = tbl[i].v;
      bus.req_bank   = tbl[i].bank;
      bus.req_index  = tbl[i].idx;
      bus.req_tag    = tbl[i].tag;
      bus.bank_ready = tbl[i].rdy;
      cycle();
      check($sformatf("vec%0d bank_valid", i), bus.bank_valid, tbl[i].exp_bv);
      check($sformatf("vec%0d req_ready", i), bus.req_ready, tbl[i].exp_rr);
      check($sformatf("vec%0d busy", i), bus.busy, tbl[i].exp_busy);
      if (tbl[i].exp_bv != 4'b0000) begin
        check($sformatf("vec%0d bank_index", i), bus.bank_index, tbl[i].exp_idx);
        check($sformatf("vec%0d bank_tag", i), bus.bank_tag[TAG_W-1:0], tbl[i].exp_tag);
`ifdef DC_TAG_WR_PARITY_EN
        check($sformatf("vec%0d parity", i), bus.bank_tag[TAG_W], ^tbl[i].exp_tag);
`endif
      end
    end

    // Async reset while bank 2 is being driven and stalled
    bus.req_valid  = 1'b1;
    bus.req_bank   = 2'd2;
    bus.req_index  = 6'd40;
    bus.req_tag    = 20'h55555;
    bus.bank_ready = 4'b1011;
    cycle();
    bus.req_valid  = 1'b0;
    cycle();
    check("mid-send bank_valid", bus.bank_valid, 4'b0100);
    #2;
    reset = 1'b0;
    mq.delete();
    showing = 1'b0;
    #1;
    check("async reset bank_valid", bus.bank_valid, 4'b0000);
    check("async reset busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cycle();
    check("after reset req_ready", bus.req_ready, 1'b1);
    check("after reset busy", bus.busy, 1'b0);
    check("after reset bank_valid", bus.bank_valid, 4'b0000);

    // Random traffic; a rejected request is held unchanged as the controller must do
    last_acc = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (!(bus.req_valid && !last_acc)) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_bank  = 2'($urandom);
        bus.req_index = 6'($urandom);
        bus.req_tag   = 20'($urandom);
      end
      bus.bank_ready = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 9) == 0) bus.bank_ready = 4'b0000;
      cycle();
      model_check("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
